// File: rtl/osc_sweep_monitor.sv
// Ring-oscillator aging monitor: sweeps each oscillator in turn, counts its edges over a
// programmable window and keeps latest/baseline count tables with a registered delta readout.
module osc_sweep_monitor #(
    parameter int NUM_OSC    = 10,
    parameter int CNT_W      = 24,
    parameter int ADDR_W     = 5,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [WIN_W-1:0]   window_i,
    input  logic               clr_base_i,
    input  logic [NUM_OSC-1:0] osc_i,
    output logic [NUM_OSC-1:0] test_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               base_vld_o,
    output logic [7:0]         sweep_cnt_o,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    input  logic [1:0]         rd_sel_i,
    output logic [CNT_W:0]     rd_data_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_COUNT  = 3'd2,
        ST_STORE  = 3'd3,
        ST_END    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0]  SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] CH_LAST     = ADDR_W'(NUM_OSC - 1);

    function automatic logic [NUM_OSC-1:0] onehot(input logic [ADDR_W-1:0] idx);
        return NUM_OSC'(1) << idx;
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [ADDR_W-1:0]  ch_r;
    logic [ADDR_W-1:0]  next_ch_s;
    logic [WIN_W-1:0]   tmr_r;
    logic [WIN_W-1:0]   win_r;
    logic [WIN_W-1:0]   win_sample_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_OSC-1:0] sync1_r;
    logic [NUM_OSC-1:0] sync2_r;
    logic [NUM_OSC-1:0] prev_r;
    logic [NUM_OSC-1:0] edge_s;
    logic               sel_edge_s;
    logic [CNT_W-1:0]   latest_r   [NUM_OSC];
    logic [CNT_W-1:0]   baseline_r [NUM_OSC];
    logic [CNT_W-1:0]   rd_latest_s;
    logic [CNT_W-1:0]   rd_base_s;
    logic [CNT_W:0]     rd_next_s;

    assign edge_s       = sync2_r & ~prev_r;
    assign sel_edge_s   = |(edge_s & onehot(ch_r));
    assign win_sample_s = (window_i == '0) ? WIN_W'(1) : window_i;

    // Oscillator synchronisers and previous-value flops for edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= osc_i;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Next-state and next-channel decode
    always_comb begin
        next_state_s = state_r;
        next_ch_s    = ch_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    next_state_s = ST_SETTLE;
                    next_ch_s    = '0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_r == SETTLE_LAST) next_state_s = ST_COUNT;
                else                      next_state_s = ST_SETTLE;
            end
            ST_COUNT: begin
                if (tmr_r == win_r - WIN_W'(1)) next_state_s = ST_STORE;
                else                            next_state_s = ST_COUNT;
            end
            ST_STORE: begin
                if (ch_r == CH_LAST) begin
                    next_state_s = ST_END;
                end else begin
                    next_state_s = ST_SETTLE;
                    next_ch_s    = ch_r + ADDR_W'(1);
                end
            end
            ST_END: begin
                if (mode_i) begin
                    next_state_s = ST_SETTLE;
                    next_ch_s    = '0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_ch_s    = '0;
            end
        endcase
    end

    // State, channel, phase timer and latched window
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            ch_r    <= '0;
            tmr_r   <= '0;
            win_r   <= WIN_W'(1);
        end else begin
            state_r <= next_state_s;
            ch_r    <= next_ch_s;
            tmr_r   <= (next_state_s != state_r || state_r == ST_IDLE) ? '0 : tmr_r + WIN_W'(1);
            if ((state_r == ST_IDLE && start_i) || (state_r == ST_END && mode_i)) begin
                win_r <= win_sample_s;
            end else begin
                win_r <= win_r;
            end
        end
    end

    // Saturating edge counter for the channel under test
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (state_r == ST_SETTLE && next_state_s == ST_COUNT) begin
            cnt_r <= '0;
        end else if (state_r == ST_COUNT && sel_edge_s && cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Status outputs registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            test_en_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            base_vld_o  <= 1'b0;
            sweep_cnt_o <= 8'd0;
        end else begin
            test_en_o <= (next_state_s == ST_SETTLE || next_state_s == ST_COUNT ||
                          next_state_s == ST_STORE) ? onehot(next_ch_s) : '0;
            busy_o    <= (next_state_s != ST_IDLE);
            done_o    <= (next_state_s == ST_END);
            if (state_r == ST_IDLE && clr_base_i) begin
                base_vld_o <= 1'b0;
            end else if (next_state_s == ST_END) begin
                base_vld_o <= 1'b1;
            end else begin
                base_vld_o <= base_vld_o;
            end
            sweep_cnt_o <= (next_state_s == ST_END) ? sweep_cnt_o + 8'd1 : sweep_cnt_o;
        end
    end

    // Latest/baseline count tables; baseline only fills while no valid baseline exists
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_OSC; i++) begin
                latest_r[i]   <= '0;
                baseline_r[i] <= '0;
            end
        end else if (state_r == ST_STORE) begin
            for (int i = 0; i < NUM_OSC; i++) begin
                if (ch_r == ADDR_W'(i)) begin
                    latest_r[i] <= cnt_r;
                    if (!base_vld_o) baseline_r[i] <= cnt_r;
                end
            end
        end
    end

    // Readout mux; addresses beyond the table fall through to zero
    always_comb begin
        rd_latest_s = '0;
        rd_base_s   = '0;
        for (int i = 0; i < NUM_OSC; i++) begin
            rd_latest_s = (rd_addr_i == ADDR_W'(i)) ? latest_r[i]   : rd_latest_s;
            rd_base_s   = (rd_addr_i == ADDR_W'(i)) ? baseline_r[i] : rd_base_s;
        end
        case (rd_sel_i)
            2'd0:    rd_next_s = {1'b0, rd_latest_s};
            2'd1:    rd_next_s = {1'b0, rd_base_s};
            2'd2:    rd_next_s = {1'b0, rd_base_s} - {1'b0, rd_latest_s};
            default: rd_next_s = '0;
        endcase
    end

    // Registered readout
    always_ff @(posedge clk) begin
        if (!rstn) rd_data_o <= '0;
        else       rd_data_o <= rd_next_s;
    end

endmodule

// File: tb/tb_osc_sweep_monitor.sv
// Randomised self-checking bench for osc_sweep_monitor against a cycle-indexed
// behavioural model of sweep timing and edge counts.
module tb_osc_sweep_monitor;

    localparam int N    = 4;
    localparam int CW   = 5;
    localparam int AW   = 3;
    localparam int WW   = 12;
    localparam int S    = 4;
    localparam int CMAX = 2**CW - 1;
    localparam int MAXC = 32768;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_i;
    logic          mode_i;
    logic [WW-1:0] window_i;
    logic          clr_base_i;
    logic [N-1:0]  osc_i;
    logic [N-1:0]  test_en_o;
    logic          busy_o;
    logic          done_o;
    logic          base_vld_o;
    logic [7:0]    sweep_cnt_o;
    logic [AW-1:0] rd_addr_i;
    logic [1:0]    rd_sel_i;
    logic [CW:0]   rd_data_o;

    osc_sweep_monitor #(
        .NUM_OSC(N), .CNT_W(CW), .ADDR_W(AW), .WIN_W(WW), .SETTLE_CYC(S)
    ) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .mode_i(mode_i),
        .window_i(window_i), .clr_base_i(clr_base_i), .osc_i(osc_i),
        .test_en_o(test_en_o), .busy_o(busy_o), .done_o(done_o),
        .base_vld_o(base_vld_o), .sweep_cnt_o(sweep_cnt_o),
        .rd_addr_i(rd_addr_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o)
    );

    always #5 clk = ~clk;

    int           cyc = 0;
    logic [N-1:0] samp [MAXC];
    int           per [N];
    bit           osc_rand;
    int           n_chk = 0;
    int           n_fail = 0;
    int           m_latest [N];
    int           m_base [N];
    bit           m_vld;
    int           m_sweeps;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Drive the oscillator pattern for the next edge, remember it, advance one clock.
    task automatic tick();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) begin
            if (osc_rand) v[k] = 1'($urandom_range(0, 1));
            else          v[k] = (((cyc + 1) % per[k]) < (per[k] / 2));
        end
        osc_i = v;
        if (cyc + 1 < MAXC) samp[cyc + 1] = v;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Rising edges seen by the counter over W counting cycles starting at cycle c0:
    // the synchronised value lags the pin by one sample, the previous value by two.
    function automatic int model_count(input int c0, input int w, input int k);
        int n = 0;
        for (int c = c0; c < c0 + w; c++) begin
            if (c >= 2 && c < MAXC && samp[c-1][k] && !samp[c-2][k]) n++;
        end
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic rd_one(input int a, input int s, output logic [CW:0] v);
        rd_addr_i = AW'(a);
        rd_sel_i  = 2'(s);
        tick();
        v = rd_data_o;
    endtask

    task automatic check_tables();
        logic [CW:0] e;
        for (int a = 0; a < 2**AW; a++) begin
            for (int s = 0; s < 4; s++) begin
                rd_addr_i = AW'(a);
                rd_sel_i  = 2'(s);
                tick();
                if (a >= N || s == 3) e = '0;
                else if (s == 0)      e = (CW+1)'(m_latest[a]);
                else if (s == 1)      e = (CW+1)'(m_base[a]);
                else                  e = (CW+1)'(m_base[a] - m_latest[a]);
                check_val($sformatf("rd_a%0d_s%0d", a, s), rd_data_o, e);
            end
        end
    endtask

    // One start from IDLE followed by nsw sweeps (continuous for all but the last).
    task automatic run(input int nsw, input int w_first, input bit clr);
        int w_eff, p, t0, endc, wnext;
        window_i   = WW'(w_first);
        mode_i     = (nsw > 1);
        start_i    = 1'b1;
        clr_base_i = clr;
        rd_addr_i  = '0;
        rd_sel_i   = 2'd3;
        if (clr) m_vld = 1'b0;
        tick();
        start_i    = 1'b0;
        clr_base_i = 1'b0;
        t0    = cyc;
        w_eff = (w_first == 0) ? 1 : w_first;
        for (int j = 0; j < nsw; j++) begin
            p     = S + w_eff + 1;
            endc  = t0 + N * p;
            wnext = $urandom_range(0, 40);
            window_i = WW'(wnext);
            mode_i   = (j < nsw - 1);
            while (cyc < endc) begin
                check_val("test_en", test_en_o, N'(1) << ((cyc - t0) / p));
                check_val("busy", busy_o, 1);
                check_val("done_idle", done_o, 0);
                check_val("base_vld", base_vld_o, m_vld);
                check_val("sweep_cnt", sweep_cnt_o, m_sweeps);
                check_val("rd_zero", rd_data_o, 0);
                start_i    = ($urandom_range(0, 3) == 0);
                clr_base_i = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 1) == 1) begin
                    rd_addr_i = AW'($urandom_range(N, 2**AW - 1));
                    rd_sel_i  = 2'($urandom_range(0, 3));
                end else begin
                    rd_addr_i = AW'($urandom_range(0, 2**AW - 1));
                    rd_sel_i  = 2'd3;
                end
                tick();
            end
            start_i    = 1'b0;
            clr_base_i = 1'b0;
            for (int k = 0; k < N; k++) begin
                m_latest[k] = model_count(t0 + k * p + S, w_eff, k);
                if (!m_vld) m_base[k] = m_latest[k];
            end
            m_vld    = 1'b1;
            m_sweeps = (m_sweeps + 1) % 256;
            check_val("done_end", done_o, 1);
            check_val("busy_end", busy_o, 1);
            check_val("test_en_end", test_en_o, 0);
            check_val("base_vld_end", base_vld_o, 1);
            check_val("sweep_cnt_end", sweep_cnt_o, m_sweeps);
            tick();
            t0    = endc + 1;
            w_eff = (wnext == 0) ? 1 : wnext;
        end
        check_val("busy_after", busy_o, 0);
        check_val("done_after", done_o, 0);
        check_val("test_en_after", test_en_o, 0);
    endtask

    initial begin
        logic [CW:0] v;
        rstn = 1'b0; start_i = 1'b0; mode_i = 1'b0; window_i = '0; clr_base_i = 1'b0;
        osc_i = '0; rd_addr_i = '0; rd_sel_i = 2'd0; osc_rand = 1'b0;
        samp[0] = '0;
        for (int k = 0; k < N; k++) begin
            per[k] = 10; m_latest[k] = 0; m_base[k] = 0;
        end
        m_vld = 1'b0; m_sweeps = 0;
        repeat (4) tick();
        check_val("rst_test_en", test_en_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_done", done_o, 0);
        check_val("rst_base_vld", base_vld_o, 0);
        check_val("rst_sweep_cnt", sweep_cnt_o, 0);
        check_val("rst_rd", rd_data_o, 0);
        rstn = 1'b1;
        repeat (3) tick();

        // Uniform period 10 over a 100-cycle window, then channel 2 slowed to period 20
        run(1, 100, 1'b0);
        check_tables();
        rd_one(1, 0, v); check_val("t1_latest1", v, 10);
        rd_one(3, 1, v); check_val("t1_base3", v, 10);
        per[2] = 20;
        run(1, 100, 1'b0);
        check_tables();
        rd_one(2, 0, v); check_val("t2_latest2", v, 5);
        rd_one(2, 1, v); check_val("t2_base2", v, 10);
        rd_one(2, 2, v); check_val("t2_delta2", v, 5);
        rd_one(0, 2, v); check_val("t2_delta0", v, 0);

        // Continuous mode for four sweeps on random oscillator data
        osc_rand = 1'b1;
        run(4, 30, 1'b0);
        check_val("t3_sweeps", sweep_cnt_o, 6);
        check_tables();

        // Saturation with a fast oscillator, baseline re-captured; then a zero window
        osc_rand = 1'b0;
        for (int k = 0; k < N; k++) per[k] = 2;
        run(1, 100, 1'b1);
        rd_one(0, 0, v); check_val("t4_sat", v, CMAX);
        check_tables();
        run(1, 0, 1'b0);
        check_tables();

        // Clear alone in IDLE, then a sweep that refills the baseline
        clr_base_i = 1'b1;
        tick();
        clr_base_i = 1'b0;
        m_vld = 1'b0;
        check_val("clr_idle", base_vld_o, 0);
        osc_rand = 1'b1;
        run(1, 25, 1'b0);
        check_tables();

        for (int r = 0; r < 8; r++) begin
            osc_rand = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) per[k] = $urandom_range(2, 24);
            run($urandom_range(1, 3), $urandom_range(0, 50), ($urandom_range(0, 3) == 0));
            check_tables();
        end

        // Reset during the counting phase of channel 1
        window_i = WW'(20); mode_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (32) tick();
        check_val("pre_rst_test_en", test_en_o, 2);
        rstn = 1'b0;
        tick();
        check_val("mid_rst_test_en", test_en_o, 0);
        check_val("mid_rst_busy", busy_o, 0);
        check_val("mid_rst_done", done_o, 0);
        check_val("mid_rst_base_vld", base_vld_o, 0);
        check_val("mid_rst_sweep_cnt", sweep_cnt_o, 0);
        check_val("mid_rst_rd", rd_data_o, 0);
        rstn = 1'b1;
        for (int k = 0; k < N; k++) begin
            m_latest[k] = 0; m_base[k] = 0;
        end
        m_vld = 1'b0; m_sweeps = 0;
        repeat (3) tick();
        check_val("post_rst_done", done_o, 0);
        check_tables();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
